// File: rtl/psum_gbf_scheduler_pkg.sv
// Shared types and default geometry for the psum GBF port scheduler.
// The beat count is derived from the PE array shape so the accumulator can import the same value.
package psum_gbf_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam int DEF_GBF_DATA_BITWIDTH  = 512;
  localparam int DEF_BRAM_ADDR_BITWIDTH = 10;

  localparam int PE_ROW                = 16;
  localparam int PE_COL                = 16;
  localparam int DATA_BITWIDTH         = 16;
  localparam int PSUM_RF_ADDR_BITWIDTH = 2;
  // 8 beats per psum RF address x 4 RF addresses = 32
  localparam int DEF_BEATS_PER_DRAIN =
    PE_ROW * PE_COL * DATA_BITWIDTH / DEF_GBF_DATA_BITWIDTH * (1 << PSUM_RF_ADDR_BITWIDTH);
  localparam int DEF_BEAT_CNT_BITWIDTH = 6;
endpackage

// File: rtl/psum_gbf_scheduler_if.sv
// Config, drain, read-out and BRAM port signals of the psum GBF scheduler.
interface psum_gbf_scheduler_if
  import psum_gbf_scheduler_pkg::*;
#(
  parameter int DW = DEF_GBF_DATA_BITWIDTH,
  parameter int AW = DEF_BRAM_ADDR_BITWIDTH
);
  logic          cfg_valid;
  logic [AW-1:0] cfg_psum_num;
  logic          pe_psum_finish;
  logic          conv_finish;
  logic          drain_start;
  logic          acc_wr_en;
  logic [DW-1:0] acc_wr_data;
  logic          drain_done;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata;
  logic          busy;
  logic          err;

  modport slave (
    input  cfg_valid, cfg_psum_num, pe_psum_finish, conv_finish, acc_wr_en, acc_wr_data,
           rd_req, rd_addr, bram_rdata,
    output drain_start, drain_done, rd_gnt, rd_valid, rd_data,
           bram_en, bram_we, bram_addr, bram_wdata, busy, err
  );

  modport master (
    output cfg_valid, cfg_psum_num, pe_psum_finish, conv_finish, acc_wr_en, acc_wr_data,
           rd_req, rd_addr, bram_rdata,
    input  drain_start, drain_done, rd_gnt, rd_valid, rd_data,
           bram_en, bram_we, bram_addr, bram_wdata, busy, err
  );
endinterface

// File: rtl/psum_wrap_counter.sv
// Enabled up-counter with synchronous clear; wraps to 0 after limit-1, limit 0 = full range.
module psum_wrap_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt
);
  logic wrap;
  assign wrap = (limit != '0) && (cnt == limit - W'(1));

  always_ff @(posedge clk or negedge reset)
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= wrap ? '0 : cnt + W'(1);
endmodule

// File: rtl/psum_gbf_scheduler.sv
// Psum GBF port controller: sequences accumulator drains into the BRAM and
// shares the single port with a read-out requester (writes never stall).
module psum_gbf_scheduler
  import psum_gbf_scheduler_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH  = DEF_GBF_DATA_BITWIDTH,
  parameter int BRAM_ADDR_BITWIDTH = DEF_BRAM_ADDR_BITWIDTH,
  parameter int BEATS_PER_DRAIN    = DEF_BEATS_PER_DRAIN,
  parameter int BEAT_CNT_BITWIDTH  = DEF_BEAT_CNT_BITWIDTH
) (
  input logic                 clk,
  input logic                 reset,
  psum_gbf_scheduler_if.slave bus
);
  state_t                        state;
  logic [BRAM_ADDR_BITWIDTH-1:0] psum_num, wr_ptr;
  logic [BEAT_CNT_BITWIDTH-1:0]  beat_cnt;
  logic pe_d, pending, conv_pend, drain_start_q, rd_valid_q, err_q;
  logic pe_rise, wr_beat, last_beat, cfg_ok, gnt, acc_err, cfg_err;

  assign pe_rise   = bus.pe_psum_finish & ~pe_d;
  assign wr_beat   = (state == DRAIN) & bus.acc_wr_en;
  assign last_beat = wr_beat & (beat_cnt == BEAT_CNT_BITWIDTH'(BEATS_PER_DRAIN - 1));
  assign cfg_ok    = bus.cfg_valid & (state == IDLE || state == DONE);
  assign acc_err   = bus.acc_wr_en & (state == READY || state == DONE);
  assign cfg_err   = bus.cfg_valid & (state == READY || state == DRAIN);
  assign gnt       = bus.rd_req & (state != IDLE) & ~wr_beat;

  // write beats pass straight through to the port with no added latency
  assign bus.rd_gnt      = gnt;
  assign bus.bram_en     = wr_beat | gnt;
  assign bus.bram_we     = wr_beat;
  assign bus.bram_addr   = wr_beat ? wr_ptr : (gnt ? bus.rd_addr : '0);
  assign bus.bram_wdata  = wr_beat ? bus.acc_wr_data : '0;
  assign bus.drain_done  = last_beat;
  assign bus.drain_start = drain_start_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = {GBF_DATA_BITWIDTH{rd_valid_q}} & bus.bram_rdata;
  assign bus.busy        = (state == DRAIN);
  assign bus.err         = err_q;

  psum_wrap_counter #(.W(BRAM_ADDR_BITWIDTH)) u_wr_ptr (
    .clk(clk), .reset(reset), .en(wr_beat), .clr(cfg_ok), .limit(psum_num), .cnt(wr_ptr)
  );

  psum_wrap_counter #(.W(BEAT_CNT_BITWIDTH)) u_beat_cnt (
    .clk(clk), .reset(reset), .en(wr_beat), .clr(cfg_ok),
    .limit(BEAT_CNT_BITWIDTH'(BEATS_PER_DRAIN)), .cnt(beat_cnt)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= IDLE;
      psum_num      <= '0;
      pending       <= 1'b0;
      conv_pend     <= 1'b0;
      pe_d          <= 1'b0;
      drain_start_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      pe_d          <= bus.pe_psum_finish;
      rd_valid_q    <= gnt;
      drain_start_q <= 1'b0;
      if (acc_err || cfg_err) err_q <= 1'b1;
      case (state)
        IDLE:
          if (bus.cfg_valid) begin
            psum_num <= bus.cfg_psum_num;
            state    <= READY;
          end
        READY:
          if (pe_rise || pending) begin
            drain_start_q <= 1'b1;
            pending       <= 1'b0;
            state         <= DRAIN;
            if (bus.conv_finish) conv_pend <= 1'b1;
          end else if (bus.conv_finish) begin
            state <= DONE;
          end
        DRAIN: begin
          // one drain request can be queued; a second one is dropped and flagged
          if (pe_rise) begin
            if (pending) err_q   <= 1'b1;
            else         pending <= 1'b1;
          end
          if (bus.conv_finish) conv_pend <= 1'b1;
          if (last_beat) begin
            if (conv_pend || bus.conv_finish) begin
              state     <= DONE;
              conv_pend <= 1'b0;
            end else begin
              state <= READY;
            end
          end
        end
        DONE:
          if (bus.cfg_valid) begin
            psum_num <= bus.cfg_psum_num;
            state    <= READY;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_psum_gbf_scheduler.sv
// Directed bench for psum_gbf_scheduler: per-cycle vector table plus hand-written reset/error sequences.
module tb_psum_gbf_scheduler;
  logic clk, reset;
  int   total, passed;

  psum_gbf_scheduler_if #(.DW(512), .AW(10)) bus ();

  psum_gbf_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model, 1-cycle read latency; only the low 16 data bits are stored
  logic [15:0] mem [0:1023];
  logic [15:0] rq;
  always @(posedge clk) begin
    if (bus.bram_en && bus.bram_we)  mem[bus.bram_addr] <= bus.bram_wdata[15:0];
    if (bus.bram_en && !bus.bram_we) rq <= mem[bus.bram_addr];
  end
  assign bus.bram_rdata = {496'd0, rq};

  typedef struct {
    logic        cfg;
    logic [9:0]  num;
    logic        pe, conv, acc;
    logic [15:0] data;
    logic        rd;
    logic [9:0]  raddr;
    logic        exp_start, exp_en, exp_we, exp_gnt, exp_done, exp_rv, exp_busy, exp_err;
    logic [9:0]  exp_addr;
    logic [15:0] exp_wdata, exp_rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int k, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s[%0d]: got %0h expected %0h", name, k, act, exp);
    else passed++;
  endtask

  function automatic logic [7:0] ctl();
    return {bus.drain_start, bus.bram_en, bus.bram_we, bus.rd_gnt,
            bus.drain_done, bus.rd_valid, bus.busy, bus.err};
  endfunction

  function automatic vec_t nv(logic busy, logic err);
    vec_t v = '{default: '0};
    v.exp_busy = busy;
    v.exp_err  = err;
    return v;
  endfunction

  function automatic vec_t beat_v(int data, int addr, bit start, bit done, bit err);
    vec_t v = nv(1'b1, err);
    v.acc = 1'b1; v.data = 16'(data);
    v.exp_en = 1'b1; v.exp_we = 1'b1; v.exp_addr = 10'(addr); v.exp_wdata = 16'(data);
    v.exp_start = start; v.exp_done = done;
    return v;
  endfunction

  function automatic vec_t rd_v(int addr, bit busy, bit err, bit rv, int rdata);
    vec_t v = nv(busy, err);
    v.rd = 1'b1; v.raddr = 10'(addr);
    v.exp_en = 1'b1; v.exp_addr = 10'(addr); v.exp_gnt = 1'b1;
    v.exp_rv = rv; v.exp_rdata = 16'(rdata);
    return v;
  endfunction

  task automatic add_drain(int d0, int a0, int num, bit err);
    for (int j = 0; j < 32; j++) tbl.push_back(beat_v(d0 + j, (a0 + j) % num, j == 0, j == 31, err));
  endtask

  task automatic apply(input vec_t v);
    bus.cfg_valid = v.cfg; bus.cfg_psum_num = v.num;
    bus.pe_psum_finish = v.pe; bus.conv_finish = v.conv;
    bus.acc_wr_en = v.acc; bus.acc_wr_data = 512'(v.data);
    bus.rd_req = v.rd; bus.rd_addr = v.raddr;
  endtask

  task automatic check_vec(input int k, input vec_t v);
    chk("ctl", k, 512'(ctl()), 512'({v.exp_start, v.exp_en, v.exp_we, v.exp_gnt,
                                     v.exp_done, v.exp_rv, v.exp_busy, v.exp_err}));
    if (v.exp_en) chk("bram_addr", k, 512'(bus.bram_addr), 512'(v.exp_addr));
    if (v.exp_we) chk("bram_wdata", k, bus.bram_wdata, 512'(v.exp_wdata));
    if (v.exp_rv) chk("rd_data", k, bus.rd_data, 512'(v.exp_rdata));
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   b;
    total = 0; passed = 0;
    reset = 1'b0;
    apply(nv(0, 0));
    repeat (2) cyc();
    chk("rst_ctl", 0, 512'(ctl()), 512'(0));
    chk("rst_addr", 0, 512'(bus.bram_addr), 512'(0));
    chk("rst_rdata", 0, bus.rd_data, 512'(0));
    reset = 1'b1;

    // IDLE: reads not granted, stray beats ignored without error
    v = nv(0, 0); v.acc = 1; v.rd = 1; v.raddr = 5; tbl.push_back(v);
    tbl.push_back(nv(0, 0));
    // drain 1: psum_num = 40, addresses 0..31
    v = nv(0, 0); v.cfg = 1; v.num = 40; tbl.push_back(v);
    v = nv(0, 0); v.pe = 1; tbl.push_back(v);
    add_drain(0, 0, 40, 0);
    tbl.push_back(nv(0, 0));
    // drain 2: 32..39 then wraps to 0..23
    v = nv(0, 0); v.pe = 1; tbl.push_back(v);
    add_drain(100, 32, 40, 0);
    tbl.push_back(nv(0, 0));
    // drain 3: beats on alternate cycles with a held read of addr 20 (holds 128)
    v = nv(0, 0); v.pe = 1; tbl.push_back(v);
    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 0) v = beat_v(200 + k / 2, (24 + k / 2) % 40, k == 0, k == 62, 0);
      else            v = rd_v(20, k != 63, 0, 0, 0);
      v.rd = 1; v.raddr = 20;
      if (k % 2 == 0 && k >= 2) begin v.exp_rv = 1; v.exp_rdata = 128; end
      tbl.push_back(v);
    end
    v = nv(0, 0); v.exp_rv = 1; v.exp_rdata = 128; tbl.push_back(v);
    // read-back: every beat of drain 3 landed
    tbl.push_back(rd_v(24, 0, 0, 0, 0));
    tbl.push_back(rd_v(15, 0, 0, 1, 200));
    tbl.push_back(rd_v(39, 0, 0, 1, 231));
    tbl.push_back(rd_v(0, 0, 0, 1, 215));
    v = nv(0, 0); v.exp_rv = 1; v.exp_rdata = 216; tbl.push_back(v);
    // drain 4: two finish pulses -> first queued, second flags err
    v = nv(0, 0); v.pe = 1; tbl.push_back(v);
    b = tbl.size();
    add_drain(300, 16, 40, 0);
    tbl[b + 3].pe = 1; tbl[b + 6].pe = 1;
    for (int j = 7; j < 32; j++) tbl[b + j].exp_err = 1;
    tbl.push_back(nv(0, 1));
    // drain 5 from the queued request; conv_finish at beat 10 -> DONE after drain
    b = tbl.size();
    add_drain(400, 8, 40, 1);
    tbl[b + 10].conv = 1;
    tbl.push_back(rd_v(8, 0, 1, 0, 0));
    v = nv(0, 1); v.exp_rv = 1; v.exp_rdata = 400; tbl.push_back(v);
    // reconfigure with psum_num = 0 (full range), addresses restart at 0
    v = nv(0, 1); v.cfg = 1; v.num = 0; tbl.push_back(v);
    v = nv(0, 1); v.pe = 1; tbl.push_back(v);
    add_drain(500, 0, 1024, 1);
    tbl.push_back(nv(0, 1));
    // drain 7, partial: four beats then a read of addr 8 (holds 508)
    v = nv(0, 1); v.pe = 1; tbl.push_back(v);
    for (int j = 0; j < 4; j++) tbl.push_back(beat_v(600 + j, 32 + j, j == 0, 0, 1));
    tbl.push_back(rd_v(8, 1, 1, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k]);
      #1;
      check_vec(k, tbl[k]);
      cyc();
    end

    // reset asserted mid-drain, between clock edges
    v = beat_v(604, 36, 0, 0, 1);
    apply(v);
    #1;
    chk("pre_rst_rv", 0, 512'(bus.rd_valid), 512'(1));
    chk("pre_rst_rdata", 0, bus.rd_data, 512'(508));
    chk("pre_rst_addr", 0, 512'(bus.bram_addr), 512'(36));
    reset = 1'b0;
    #1;
    chk("async_rst_ctl", 0, 512'(ctl()), 512'(0));
    chk("async_rst_addr", 0, 512'(bus.bram_addr), 512'(0));
    chk("async_rst_wdata", 0, bus.bram_wdata, 512'(0));
    cyc(); cyc();
    reset = 1'b1;
    #1;
    chk("idle_acc_ctl", 0, 512'(ctl()), 512'(0));
    cyc();
    chk("idle_acc_err", 0, 512'(ctl()), 512'(0));
    apply(nv(0, 0)); bus.cfg_valid = 1; bus.cfg_psum_num = 40;
    cyc();
    apply(nv(0, 0)); bus.pe_psum_finish = 1;
    cyc();
    apply(beat_v(700, 0, 1, 0, 0));
    #1;
    check_vec(0, beat_v(700, 0, 1, 0, 0));

    // beat outside DRAIN flags err
    reset = 1'b0; apply(nv(0, 0));
    cyc();
    reset = 1'b1; bus.cfg_valid = 1; bus.cfg_psum_num = 40;
    cyc();
    apply(nv(0, 0)); bus.acc_wr_en = 1;
    #1;
    chk("ready_acc_en", 0, 512'(bus.bram_en), 512'(0));
    cyc();
    apply(nv(0, 0));
    #1;
    chk("ready_acc_err", 0, 512'(bus.err), 512'(1));

    // cfg in READY flags err
    reset = 1'b0;
    cyc();
    reset = 1'b1; bus.cfg_valid = 1; bus.cfg_psum_num = 40;
    cyc();
    chk("cfg_ok_err", 0, 512'(bus.err), 512'(0));
    cyc();
    apply(nv(0, 0));
    #1;
    chk("ready_cfg_err", 0, 512'(bus.err), 512'(1));
    chk("ready_cfg_busy", 0, 512'(bus.busy), 512'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/psum_gbf_scheduler.md
Name: psum_gbf_scheduler

Overview:
Controller for the psum global-buffer port that sits between the PE-array psum accumulator and the single-port psum GBF BRAM.
- Sequences each accumulator drain: start pulse, fixed beat count, write address generation with wrap over the configured psum line count.
- Arbitrates the BRAM port between the drain write stream and a read-out requester (writeback / next-layer fetch).
- Replaces per-layer metadata file loading with a runtime config port.

Parameters:
GBF_DATA_BITWIDTH, 512, BRAM word width (one drain beat)
BRAM_ADDR_BITWIDTH, 10, psum GBF address width
BEATS_PER_DRAIN, 32, write beats per drain (8 beats per psum RF address x 4 RF addresses)
BEAT_CNT_BITWIDTH, 6, width of beat counter (must hold BEATS_PER_DRAIN)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
cfg_valid  in  1  load cfg_psum_num (accepted only in IDLE or DONE)
cfg_psum_num  in  BRAM_ADDR_BITWIDTH  psum lines per tile; 0 means 2^BRAM_ADDR_BITWIDTH
pe_psum_finish  in  1  PE array psum ready (level or pulse; rising edge sampled)
conv_finish  in  1  layer complete (pulse)
drain_start  out  1  1-cycle pulse telling accumulator to begin a drain
acc_wr_en  in  1  accumulator write beat valid
acc_wr_data  in  GBF_DATA_BITWIDTH  accumulator write beat
drain_done  out  1  1-cycle pulse after last beat of a drain
rd_req  in  1  read-out request, held until rd_gnt
rd_addr  in  BRAM_ADDR_BITWIDTH  read address
rd_gnt  out  1  read accepted this cycle
rd_valid  out  1  rd_data valid (1 cycle after rd_gnt)
rd_data  out  GBF_DATA_BITWIDTH  read data
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable
bram_addr  out  BRAM_ADDR_BITWIDTH  BRAM address
bram_wdata  out  GBF_DATA_BITWIDTH  BRAM write data
bram_rdata  in  GBF_DATA_BITWIDTH  BRAM read data, 1-cycle latency
busy  out  1  high in DRAIN
err  out  1  sticky protocol error, cleared only by reset

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - psum_num = 0, wr_ptr = 0, beat_cnt = 0, pending = 0, conv_pend = 0.
  - All outputs 0.
- States and transitions:
  - IDLE: waits for cfg_valid, then latches psum_num and clears wr_ptr -> READY.
  - READY:
    - pe_psum_finish rise or pending=1: drain_start=1 for one cycle, pending cleared -> DRAIN.
    - Otherwise, conv_finish -> DONE.
  - DRAIN:
    - Each acc_wr_en beat: bram_en=bram_we=1, bram_addr=wr_ptr, bram_wdata=acc_wr_data (combinational pass-through, 0 added latency).
    - wr_ptr increments and wraps to 0 at psum_num-1; the wrap persists across drains.
    - beat_cnt increments on each beat.
    - On beat BEATS_PER_DRAIN-1: beat_cnt=0 and drain_done pulses in the same cycle. Next state is DONE if conv_pend=1, else READY.
  - DONE: the port stays available to reads. cfg_valid reloads psum_num, clears wr_ptr and err-free state -> READY.
- Simultaneous events:
  - pe_psum_finish rise during DRAIN sets pending (one-deep). A second rise while pending=1 sets err and is dropped.
  - conv_finish during DRAIN sets conv_pend. The drain completes before DONE.
  - conv_finish together with pe_psum_finish in READY: the drain wins and conv_pend is set.
- Arbitration:
  - A write beat has absolute priority because the accumulator stream cannot stall.
  - rd_gnt = rd_req & ~(DRAIN & acc_wr_en). A granted read drives bram_en=1, bram_we=0, bram_addr=rd_addr.
  - rd_valid is rd_gnt delayed one cycle; rd_data=bram_rdata when rd_valid.
  - Reads are granted in every state except IDLE.
- Errors (set err, no other effect):
  - acc_wr_en outside DRAIN: beat ignored.
  - cfg_valid in READY or DRAIN: ignored.
  - pending overflow (see simultaneous events).
- Reset mid-drain: immediate return to IDLE, partial drain discarded, rd_valid cleared.

Decomposition:
- Shared package holds:
  - State enum IDLE/READY/DRAIN/DONE (2 bits).
  - Default widths (GBF_DATA_BITWIDTH, BRAM_ADDR_BITWIDTH).
  - Derived BEATS_PER_DRAIN = ROW*COL*DATA_BITWIDTH/GBF_DATA_BITWIDTH * 2^PSUM_RF_ADDR_BITWIDTH, shared with the accumulator.
- One natural sub-module, psum_wrap_counter: an address counter with enable, synchronous clear, and wrap at a programmable limit where limit 0 means full range. It serves wr_ptr and is reusable for beat_cnt.

Test Plan:
- Reset, cfg psum_num=40, pe_psum_finish pulse, 32 acc_wr_en beats with data=beat index -> drain_start 1 cycle after the finish; bram_addr 0..31 with bram_we=1; drain_done on beat 31; state READY.
- Second drain with psum_num=40 -> addresses 32..39 then wrap to 0..23; drain_done after 32 beats.
- rd_req held during a drain with acc_wr_en on alternate cycles -> rd_gnt only on idle cycles; rd_valid one cycle later with BRAM model data; no write beat is lost.
- pe_psum_finish twice during one drain -> first queued (new drain_start right after drain_done), second sets err=1.
- conv_finish at beat 10 of a drain -> drain completes all 32 beats, then DONE; reads are still granted; cfg_valid with psum_num=0 -> READY, next drain addresses 0..31.
- reset asserted at beat 5 -> all outputs 0 asynchronously, IDLE; acc_wr_en afterwards ignored; err stays 0 until cfg.
